// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants, channel-index width helper and index type for stream_mux_arbiter.
package stream_mux_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int MAX_BURST_DEF = 4;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [ch_w(NUM_CH_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/stream_mux_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over req with a registered priority pointer.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic [CH_W-1:0]   advance_idx,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = (int'(ptr_q) + k) % NUM_CH;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

    // Winner drops to lowest priority; idle cycles keep the pointer.
    always_comb ptr_d = advance ? ((int'(advance_idx) == NUM_CH - 1) ? '0 : advance_idx + 1'b1) : ptr_q;

    always_ff @(posedge clk)
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;

endmodule

// File: rtl/stream_mux_arbiter.sv
// stream_mux_arbiter: round-robin merge of NUM_CH valid/ready streams into one registered stream tagged with its source channel.
// Optional burst lock (keep a channel granted for up to MAX_BURST beats) is enabled by defining MUX_BURST_LOCK_EN.
module stream_mux_arbiter
    import stream_mux_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CH_W      = ch_w(NUM_CH),
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_sel,
    input  logic                     out_ready
);

    if (NUM_CH < 2 || NUM_CH > 16 || MAX_BURST < 1) begin : g_bad_cfg
        $error("stream_mux_arbiter: unsupported NUM_CH or MAX_BURST");
    end

    logic [NUM_CH-1:0] req, grant;
    logic [CH_W-1:0]   grant_idx;
    logic              load_en, xfer;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_sel_q, out_sel_d;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .advance     (xfer),
        .advance_idx (grant_idx),
        .grant       (grant),
        .grant_idx   (grant_idx)
    );

`ifdef MUX_BURST_LOCK_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0] burst_q, burst_d, burst_nxt;
    logic [CH_W-1:0]    lock_idx_q, lock_idx_d;
    logic               lock_act;

    // A lock only masks others while its owner still requests; the pointer already sits at owner+1.
    always_comb begin
        lock_act = (burst_q != '0) & in_valid[lock_idx_q];
        req      = lock_act ? (in_valid & (NUM_CH'(1) << lock_idx_q)) : in_valid;
    end

    always_comb begin
        burst_nxt  = (lock_act ? burst_q : '0) + 1'b1;
        lock_idx_d = (xfer & ~lock_act) ? grant_idx : lock_idx_q;
        burst_d    = xfer ? ((burst_nxt == BURST_W'(MAX_BURST)) ? '0 : burst_nxt)
                          : ((load_en & ~lock_act) ? '0 : burst_q);
    end

    always_ff @(posedge clk)
        if (rst) begin
            burst_q    <= '0;
            lock_idx_q <= '0;
        end else begin
            burst_q    <= burst_d;
            lock_idx_q <= lock_idx_d;
        end
`else
    assign req = in_valid;
`endif

    always_comb begin
        load_en     = ~out_valid_q | out_ready;
        in_ready    = grant & {NUM_CH{load_en & ~rst}};
        xfer        = |in_ready;
        out_valid_d = xfer | (out_valid_q & ~out_ready);
        out_data_d  = xfer ? in_data[int'(grant_idx)*DATA_W +: DATA_W] : out_data_q;
        out_sel_d   = xfer ? grant_idx : out_sel_q;
    end

    always_ff @(posedge clk)
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// tb_stream_mux_arbiter: directed stimulus with an expected-beat queue checked by an independent output monitor.
module tb_stream_mux_arbiter;

    localparam int DW = 8;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   in_valid = '1;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]   in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   dv [NC];
    logic [15:0]     exp_q [$];
    int              checks = 0;
    int              errors = 0;

    stream_mux_arbiter #(.DATA_W(DW), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = dv[i];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int ch);
        exp_q.push_back({8'(ch), dv[ch]});
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Output monitor: every accepted output beat must match the head of the expected queue.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: unexpected sel=%0d data=%0h, none expected", out_sel, out_data);
            end else
                chk("beat", {8'(out_sel), out_data}, 32'(exp_q.pop_front()));
        end
    end

    initial begin
        dv[0] = 8'hA0; dv[1] = 8'hB1; dv[2] = 8'hC2; dv[3] = 8'hD3;
        // Reset with all channels requesting
        @(posedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
`ifdef MUX_BURST_LOCK_EN
        for (int i = 0; i < 8; i++) push(i / 4);
`else
        for (int i = 0; i < 8; i++) push(i % 4);
`endif
        @(negedge clk);
        chk("first_grant", 32'(in_ready), 32'b0001);
        repeat (8) @(posedge clk);
        #1 in_valid = '0;
        repeat (2) @(posedge clk);

        // Backpressure on ch2
        pulse_reset();
        out_ready = 1'b0; in_valid = 4'b0100; dv[2] = 8'h01; push(2);
        @(posedge clk); #1 dv[2] = 8'h5A; push(2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_sel", 32'(out_sel), 2);
            chk("bp_data", 32'(out_data), 32'h01);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'b0100);
        @(posedge clk); #1 in_valid = '0;
        @(posedge clk); @(negedge clk);
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_idle_ready", 32'(in_ready), 0);

        // Skip and wrap: pointer at 1, only ch3 and ch0 valid
        pulse_reset();
        in_valid = 4'b0001; push(0);
        @(posedge clk); #1 in_valid = 4'b0000;
        @(posedge clk); #1 in_valid = 4'b1001; push(3); push(0);
        @(negedge clk);
        chk("skip_grant_ch3", 32'(in_ready), 32'b1000);
        @(posedge clk); #1 in_valid = 4'b0001;
        @(negedge clk);
        chk("wrap_grant_ch0", 32'(in_ready), 32'b0001);
        @(posedge clk); #1 in_valid = '0;
        repeat (2) @(posedge clk);

        // Reset mid-stream discards the held beat and the pointer
        #1 out_ready = 1'b0; in_valid = 4'b0010;
        @(posedge clk); #1 in_valid = '0;
        @(negedge clk);
        chk("mid_valid_before", 32'(out_valid), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 0);
        @(posedge clk); @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; push(0);
        @(negedge clk);
        chk("mid_ptr_zero", 32'(in_ready), 32'b0001);
        @(posedge clk); #1 in_valid = '0;
        repeat (3) @(posedge clk);

`ifdef MUX_BURST_LOCK_EN
        // Full bursts, then an early release when ch1 drops
        pulse_reset();
        in_valid = 4'b0110;
        for (int i = 0; i < 8; i++) push(1 + i / 4);
        repeat (8) @(posedge clk);
        #1 in_valid = '0;
        pulse_reset();
        in_valid = 4'b0110;
        push(1); push(1); push(2); push(2); push(2); push(2);
        repeat (2) @(posedge clk);
        #1 in_valid = 4'b0100;
        repeat (4) @(posedge clk);
        #1 in_valid = '0;
        repeat (3) @(posedge clk);
`endif

        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
